sample_record_buffer: RTL and testbench

Parametrised serial-sample recorder for the CAN timing-analysis capture path. It edge-detects a sample strobe and shifts the sampled bus bit into a WORD_W-bit word. The bit order is selectable. Each completed word is queued in a first-word-fall-through FIFO and drained through a valid/ready port. Overflow, flush and running-status reporting extend the fixed 32-bit single-register recorder it replaces.

---
 rtl/record_pkg.sv | 18 +
 rtl/record_fifo.sv | 65 ++++++
 rtl/sample_record_buffer.sv | 110 +++++++++++
 tb/tb_sample_record_buffer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/record_pkg.sv
// Shared types and width helpers for the sample record buffer and its FIFO.
package record_pkg;

  typedef enum logic {
    LSB_FIRST   = 1'b0,
    MSB_FIRST_E = 1'b1
  } bit_order_e;

  // Width of an occupancy count that must represent 0..depth inclusive.
  function automatic int levelWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int countWidth(input int wordW);
    return (wordW < 2) ? 1 : $clog2(wordW);
  endfunction

endpackage

// File: rtl/record_fifo.sv
// First-word-fall-through FIFO: the head entry is visible on rdData_o without a read cycle.
module record_fifo
  import record_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic                          flush_i,
  input  logic [WIDTH-1:0]              wrData_i,
  output logic [WIDTH-1:0]              rdData_o,
  output logic [levelWidth(DEPTH)-1:0]  level_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = levelWidth(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wrPtr_q, wrPtr_d;
  logic [AW:0]      rdPtr_q, rdPtr_d;
  logic [AW:0]      ptrDiff;
  logic             pushOk;
  logic             popOk;

  // The extra wrap bit separates full (wrap bits differ) from empty (pointers equal).
  always_comb begin
    empty_o  = (wrPtr_q == rdPtr_q);
    full_o   = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    popOk    = pop_i & ~empty_o & ~flush_i;
    pushOk   = push_i & (~full_o | popOk) & ~flush_i;
    ptrDiff  = wrPtr_q - rdPtr_q;
    level_o  = LW'(ptrDiff);
    rdData_o = mem_q[rdPtr_q[AW-1:0]];
    wrPtr_d  = wrPtr_q;
    rdPtr_d  = rdPtr_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (pushOk) wrPtr_d = wrPtr_q + 1'b1;
      if (popOk)  rdPtr_d = rdPtr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage needs no reset: the head is only observed when the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (pushOk) mem_q[wrPtr_q[AW-1:0]] <= wrData_i;
  end

endmodule

// File: rtl/sample_record_buffer.sv
// Serial-sample recorder: edge-detects samplePulse, shifts dIn into a word and queues
// completed words in a FWFT FIFO with sticky overflow reporting.
module sample_record_buffer
  import record_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 0
) (
  input  logic                               clk,
  input  logic                               resetN,
  input  logic                               enable,
  input  logic                               samplePulse,
  input  logic                               dIn,
  input  logic                               flush,
  input  logic                               outReady,
  output logic [WORD_W-1:0]                  outData,
  output logic                               outValid,
  output logic [levelWidth(FIFO_DEPTH)-1:0]  level,
  output logic [countWidth(WORD_W)-1:0]      bitCount,
  output logic [WORD_W-1:0]                  partialWord,
  output logic                               overflow
);

  localparam int CW = countWidth(WORD_W);
  localparam int LW = levelWidth(FIFO_DEPTH);
  localparam bit_order_e ORDER = (MSB_FIRST != 0) ? MSB_FIRST_E : LSB_FIRST;

  logic              pulseQ_q;
  logic [WORD_W-1:0] partialWord_q, partialWord_d;
  logic [CW-1:0]     bitCount_q, bitCount_d;
  logic              overflow_q, overflow_d;

  logic              strobe;
  logic              sampleEn;
  logic              wordDone;
  logic              popReq;
  logic              pushReq;
  logic [WORD_W-1:0] shifted;

  logic [WORD_W-1:0] fifoHead;
  logic [LW-1:0]     fifoLevel;
  logic              fifoFull;
  logic              fifoEmpty;

  // Flush wins over sampling, pushing and popping in the same cycle.
  always_comb begin
    strobe   = samplePulse & ~pulseQ_q;
    sampleEn = strobe & enable & ~flush;
    if (ORDER == MSB_FIRST_E) shifted = {partialWord_q[WORD_W-2:0], dIn};
    else                      shifted = {dIn, partialWord_q[WORD_W-1:1]};
    wordDone = sampleEn && (bitCount_q == CW'(WORD_W - 1));
    popReq   = ~fifoEmpty & outReady & ~flush;
    pushReq  = wordDone & (~fifoFull | popReq);

    partialWord_d = partialWord_q;
    bitCount_d    = bitCount_q;
    overflow_d    = overflow_q;
    if (flush) begin
      partialWord_d = '0;
      bitCount_d    = '0;
      overflow_d    = 1'b0;
    end else if (sampleEn) begin
      partialWord_d = shifted;
      bitCount_d    = wordDone ? '0 : bitCount_q + CW'(1);
      if (wordDone && fifoFull && !popReq) overflow_d = 1'b1;
    end
  end

  // The edge-detect register tracks the pulse even while disabled or flushing.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      pulseQ_q      <= 1'b0;
      partialWord_q <= '0;
      bitCount_q    <= '0;
      overflow_q    <= 1'b0;
    end else begin
      pulseQ_q      <= samplePulse;
      partialWord_q <= partialWord_d;
      bitCount_q    <= bitCount_d;
      overflow_q    <= overflow_d;
    end
  end

  record_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk      (clk),
    .resetN   (resetN),
    .push_i   (pushReq),
    .pop_i    (popReq),
    .flush_i  (flush),
    .wrData_i (shifted),
    .rdData_o (fifoHead),
    .level_o  (fifoLevel),
    .full_o   (fifoFull),
    .empty_o  (fifoEmpty)
  );

  always_comb begin
    outValid    = ~fifoEmpty;
    outData     = outValid ? fifoHead : '0;
    level       = fifoLevel;
    bitCount    = bitCount_q;
    partialWord = partialWord_q;
    overflow    = overflow_q;
  end

endmodule

// File: tb/tb_sample_record_buffer.sv
// Directed bench for sample_record_buffer: LSB-first and MSB-first instances share stimulus.
module tb_sample_record_buffer;

  logic clk = 1'b0;
  logic resetN, enable, samplePulse, dIn, flush, outReady;

  logic [31:0] lsbData, lsbPartial, msbData, msbPartial;
  logic        lsbValid, lsbOverflow, msbValid, msbOverflow;
  logic [2:0]  lsbLevel, msbLevel;
  logic [4:0]  lsbCount, msbCount;

  int testsRun  = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  sample_record_buffer #(.WORD_W(32), .FIFO_DEPTH(4), .MSB_FIRST(0)) dutLsb (
    .clk(clk), .resetN(resetN), .enable(enable), .samplePulse(samplePulse),
    .dIn(dIn), .flush(flush), .outReady(outReady), .outData(lsbData),
    .outValid(lsbValid), .level(lsbLevel), .bitCount(lsbCount),
    .partialWord(lsbPartial), .overflow(lsbOverflow)
  );

  sample_record_buffer #(.WORD_W(32), .FIFO_DEPTH(4), .MSB_FIRST(1)) dutMsb (
    .clk(clk), .resetN(resetN), .enable(enable), .samplePulse(samplePulse),
    .dIn(dIn), .flush(flush), .outReady(outReady), .outData(msbData),
    .outValid(msbValid), .level(msbLevel), .bitCount(msbCount),
    .partialWord(msbPartial), .overflow(msbOverflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One strobe: pulse high for the sampling edge, low for the following edge.
  task automatic applyStimulus(input logic bitVal);
    samplePulse = 1'b1;
    dIn         = bitVal;
    tick();
    samplePulse = 1'b0;
    tick();
  endtask

  task automatic sendBits(input logic [31:0] word, input int count);
    for (int i = 0; i < count; i++) applyStimulus(word[i]);
  endtask

  task automatic doFlush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [31:0] words [5];
  logic [31:0] stream;

  initial begin
    resetN = 1'b0; enable = 1'b1; samplePulse = 1'b0; dIn = 1'b0;
    flush = 1'b0; outReady = 1'b0;
    words[0] = 32'h1111_1111; words[1] = 32'h2222_2222; words[2] = 32'h3333_3333;
    words[3] = 32'h4444_4444; words[4] = 32'h5555_5555;
    stream = 32'hA5A5_0F0F;
    repeat (3) tick();

    checkOutput("rst_outData", lsbData, 0);
    checkOutput("rst_outValid", lsbValid, 0);
    checkOutput("rst_level", lsbLevel, 0);
    checkOutput("rst_bitCount", lsbCount, 0);
    checkOutput("rst_partial", lsbPartial, 0);
    checkOutput("rst_overflow", lsbOverflow, 0);

    // Pulse already high when reset releases counts as one edge.
    samplePulse = 1'b1; dIn = 1'b1;
    tick();
    resetN = 1'b1;
    tick();
    checkOutput("relHigh_bitCount", lsbCount, 1);
    checkOutput("relHigh_partialLsb", lsbPartial, 32'h8000_0000);
    checkOutput("relHigh_partialMsb", msbPartial, 32'h0000_0001);
    samplePulse = 1'b0;
    tick();
    doFlush();
    checkOutput("flush1_bitCount", lsbCount, 0);

    // Full word, consumer always ready.
    outReady = 1'b1;
    sendBits(stream, 31);
    checkOutput("w1_validBefore", lsbValid, 0);
    samplePulse = 1'b1; dIn = stream[31];
    tick();
    checkOutput("w1_outValid", lsbValid, 1);
    checkOutput("w1_outDataLsb", lsbData, 32'hA5A5_0F0F);
    checkOutput("w1_outDataMsb", msbData, 32'hF0F0_A5A5);
    checkOutput("w1_bitCount", lsbCount, 0);
    checkOutput("w1_level", lsbLevel, 1);
    samplePulse = 1'b0;
    tick();
    checkOutput("w1_levelAfterPop", lsbLevel, 0);
    checkOutput("w1_validAfterPop", lsbValid, 0);
    checkOutput("w1_dataAfterPop", lsbData, 0);

    // Enable gating and pulse held across enable rise.
    doFlush();
    sendBits(32'hFFFF_FFFF, 10);
    checkOutput("en_bitCount10", lsbCount, 10);
    checkOutput("en_partial10", lsbPartial, 32'hFFC0_0000);
    enable = 1'b0;
    sendBits(32'h0000_0000, 3);
    checkOutput("en_bitCountHeld", lsbCount, 10);
    checkOutput("en_partialHeld", lsbPartial, 32'hFFC0_0000);
    samplePulse = 1'b1; dIn = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    tick();
    checkOutput("en_heldHighCount", lsbCount, 10);
    checkOutput("en_heldHighPartial", lsbPartial, 32'hFFC0_0000);
    samplePulse = 1'b0;
    tick();
    applyStimulus(1'b1);
    checkOutput("en_resumeCount", lsbCount, 11);
    checkOutput("en_resumePartial", lsbPartial, 32'hFFE0_0000);

    // Overflow: five words into a four-deep FIFO with no consumer.
    doFlush();
    outReady = 1'b0;
    for (int w = 0; w < 4; w++) sendBits(words[w], 32);
    checkOutput("ovf_level4", lsbLevel, 4);
    checkOutput("ovf_notYet", lsbOverflow, 0);
    sendBits(words[4], 32);
    checkOutput("ovf_levelStill4", lsbLevel, 4);
    checkOutput("ovf_set", lsbOverflow, 1);
    outReady = 1'b1;
    for (int w = 0; w < 4; w++) begin
      checkOutput($sformatf("ovf_drain%0d", w), lsbData, {32'h0, words[w]});
      tick();
    end
    outReady = 1'b0;
    checkOutput("ovf_emptyValid", lsbValid, 0);
    checkOutput("ovf_sticky", lsbOverflow, 1);

    // Full FIFO with a pop on the completing edge: no drop.
    doFlush();
    checkOutput("full_flushOvf", lsbOverflow, 0);
    for (int w = 0; w < 4; w++) sendBits(words[w], 32);
    sendBits(words[4], 31);
    samplePulse = 1'b1; dIn = words[4][31]; outReady = 1'b1;
    tick();
    outReady = 1'b0; samplePulse = 1'b0;
    checkOutput("full_level", lsbLevel, 4);
    checkOutput("full_overflow", lsbOverflow, 0);
    checkOutput("full_head", lsbData, {32'h0, words[1]});
    tick();
    outReady = 1'b1;
    for (int w = 1; w < 5; w++) begin
      checkOutput($sformatf("full_drain%0d", w), lsbData, {32'h0, words[w]});
      tick();
    end
    outReady = 1'b0;

    // Flush on a strobe cycle with partial word, queued words and overflow.
    doFlush();
    for (int w = 0; w < 5; w++) sendBits(words[w], 32);
    outReady = 1'b1;
    tick();
    tick();
    outReady = 1'b0;
    sendBits(32'hFFFF_FFFF, 17);
    checkOutput("fl_pre_bitCount", lsbCount, 17);
    checkOutput("fl_pre_level", lsbLevel, 2);
    checkOutput("fl_pre_overflow", lsbOverflow, 1);
    samplePulse = 1'b1; dIn = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("fl_bitCount", lsbCount, 0);
    checkOutput("fl_partial", lsbPartial, 0);
    checkOutput("fl_level", lsbLevel, 0);
    checkOutput("fl_outValid", lsbValid, 0);
    checkOutput("fl_overflow", lsbOverflow, 0);
    tick();
    checkOutput("fl_noLateStrobe", lsbCount, 0);
    samplePulse = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
